// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the memory stage and one BRAM port.
//   It decodes funct3 into access size and signedness. It builds byte enables and
//   lane-shifted store data, and it sign- or zero-extends load data. An access that
//   crosses a word boundary is issued as two back-to-back BRAM beats.
// Ports:
//   clk, reset_n                 clock and synchronous active-low reset
//   req_valid/req_ready          request handshake; ready only while idle
//   req_we, req_funct3           store select and RISC-V size/sign code
//   req_addr, req_wdata          byte address and right-justified store data
//   rsp_valid/rsp_rdata/rsp_err  one-cycle registered completion
//   mem_en/mem_we/mem_addr       BRAM control, one mem_en cycle per beat
//   mem_wdata/mem_rdata          BRAM data; read data arrives BRAM_LAT cycles after mem_en
module lsu_align #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int BRAM_LAT       = 1,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [2:0]                            req_funct3,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [XLEN-1:0]                       req_wdata,
  output logic                                  rsp_valid,
  output logic [XLEN-1:0]                       rsp_rdata,
  output logic                                  rsp_err,
  output logic                                  mem_en,
  output logic [XLEN/8-1:0]                     mem_we,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0]      mem_addr,
  output logic [XLEN-1:0]                       mem_wdata,
  input  logic [XLEN-1:0]                       mem_rdata
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int WAW  = ADDR_W - OFFW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_ISSUE1 = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Extend the low (1 << sz) bytes of d to XLEN bits, with sign fill unless uns is set.
  function automatic logic [XLEN-1:0] ext_load(input logic [XLEN-1:0] d,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [3:0]      nbytes;
    logic            sgn;
    logic [XLEN-1:0] r;
    nbytes = 4'd1 << sz;
    case (sz)
      2'd0:    sgn = d[7];
      2'd1:    sgn = d[15];
      2'd2:    sgn = d[31];
      default: sgn = d[XLEN-1];
    endcase
    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes)) begin
        r[8*i +: 8] = d[8*i +: 8];
      end else begin
        r[8*i +: 8] = uns ? 8'h00 : {8{sgn}};
      end
    end
    return r;
  endfunction

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                mem_en_q, mem_en_d;
  logic [NB-1:0]       mem_we_q, mem_we_d;
  logic [WAW-1:0]      mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFFW-1:0]     off_q, off_d;
  logic                cross_q, cross_d;
  logic [WAW-1:0]      addr1_q, addr1_d;
  logic [NB-1:0]       be1_q, be1_d;
  logic [XLEN-1:0]     wdata1_q, wdata1_d;
  logic [XLEN-1:0]     beat0_q, beat0_d;
  logic                beat0_got_q, beat0_got_d;
  // One bit per cycle of BRAM latency; the top bit marks the cycle where read data is valid.
  logic [BRAM_LAT-1:0] pipe_q, pipe_d;

  logic [OFFW-1:0]     off_s;
  logic [3:0]          size_s;
  logic                cross_s;
  logic                legal_s;
  logic                err_s;
  logic [2*NB-1:0]     mask_s;
  logic [2*NB-1:0]     be_full_s;
  logic [2*XLEN-1:0]   wd_full_s;
  logic [WAW-1:0]      waddr0_s;
  logic                hit_s;
  logic                last_s;
  logic [XLEN-1:0]     lo_s;
  logic [XLEN-1:0]     hi_s;
  logic [XLEN-1:0]     merged_s;

  // Request decode: size, offset, legality, word-crossing, enables and shifted data.
  always_comb begin
    off_s     = req_addr[OFFW-1:0];
    size_s    = 4'd1 << req_funct3[1:0];
    cross_s   = (5'(off_s) + 5'(size_s)) > 5'(NB);
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
      3'b011:  legal_s = (XLEN == 64);
      3'b110:  legal_s = (XLEN == 64) && !req_we;
      default: legal_s = 1'b0;
    endcase
    err_s     = !legal_s || (cross_s && (MISALIGN_SPLIT == 0));
    mask_s    = ((2*NB)'(1) << size_s) - (2*NB)'(1);
    be_full_s = mask_s << off_s;
    wd_full_s = {{XLEN{1'b0}}, req_wdata} << {off_s, 3'b000};
    waddr0_s  = req_addr[ADDR_W-1:OFFW];
  end

  // Load merge: beat1 supplies the upper word only on a split access.
  always_comb begin
    hit_s    = pipe_q[BRAM_LAT-1];
    last_s   = hit_s && (!cross_q || beat0_got_q);
    lo_s     = cross_q ? beat0_q : mem_rdata;
    hi_s     = cross_q ? mem_rdata : {XLEN{1'b0}};
    merged_s = XLEN'({hi_s, lo_s} >> {off_q, 3'b000});
  end

  // Next-state logic for the access FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = {XLEN{1'b0}};
    rsp_err_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = {NB{1'b0}};
    mem_addr_d  = {WAW{1'b0}};
    mem_wdata_d = {XLEN{1'b0}};
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    cross_d     = cross_q;
    addr1_d     = addr1_q;
    be1_d       = be1_q;
    wdata1_d    = wdata1_q;
    beat0_d     = beat0_q;
    beat0_got_d = beat0_got_q;

    // Only load beats are tracked, so a late store beat can never look like read data.
    pipe_d      = {BRAM_LAT{1'b0}};
    pipe_d[0]   = mem_en_q & ~we_q;
    for (int i = 1; i < BRAM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (hit_s && cross_q && !beat0_got_q) begin
      beat0_d     = mem_rdata;
      beat0_got_d = 1'b1;
    end else begin
      beat0_d     = beat0_q;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          size_d      = req_funct3[1:0];
          uns_d       = req_funct3[2];
          off_d       = off_s;
          cross_d     = cross_s;
          addr1_d     = waddr0_s + WAW'(1);
          be1_d       = NB'(be_full_s >> NB);
          wdata1_d    = wd_full_s[2*XLEN-1:XLEN];
          beat0_got_d = 1'b0;
          if (err_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end else begin
            mem_en_d    = 1'b1;
            mem_addr_d  = waddr0_s;
            mem_we_d    = req_we ? NB'(be_full_s) : {NB{1'b0}};
            mem_wdata_d = wd_full_s[XLEN-1:0];
            state_d     = S_ISSUE0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE0: begin
        if (cross_q) begin
          mem_en_d    = 1'b1;
          mem_addr_d  = addr1_q;
          mem_we_d    = we_q ? be1_q : {NB{1'b0}};
          mem_wdata_d = wdata1_q;
          state_d     = S_ISSUE1;
        end else if (we_q) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_ISSUE1: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (last_s) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ext_load(merged_s, size_q, uns_q);
          state_d     = S_RESP;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {XLEN{1'b0}};
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= {NB{1'b0}};
      mem_addr_q  <= {WAW{1'b0}};
      mem_wdata_q <= {XLEN{1'b0}};
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= {OFFW{1'b0}};
      cross_q     <= 1'b0;
      addr1_q     <= {WAW{1'b0}};
      be1_q       <= {NB{1'b0}};
      wdata1_q    <= {XLEN{1'b0}};
      beat0_q     <= {XLEN{1'b0}};
      beat0_got_q <= 1'b0;
      pipe_q      <= {BRAM_LAT{1'b0}};
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      cross_q     <= cross_d;
      addr1_q     <= addr1_d;
      be1_q       <= be1_d;
      wdata1_q    <= wdata1_d;
      beat0_q     <= beat0_d;
      beat0_got_q <= beat0_got_d;
      pipe_q      <= pipe_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align (XLEN=32, BRAM_LAT=1). The main instance splits word-crossing
// accesses. A second instance built with MISALIGN_SPLIT=0 covers the error path.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid_ns = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_rdata_ns = 32'h0;

  logic        req_ready, rsp_valid, rsp_err, mem_en;
  logic [31:0] rsp_rdata, mem_wdata;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic        req_ready_ns, rsp_valid_ns, rsp_err_ns, mem_en_ns;
  logic [31:0] rsp_rdata_ns, mem_wdata_ns;
  logic [3:0]  mem_we_ns;
  logic [29:0] mem_addr_ns;

  int total_cnt = 0;
  int bad_cnt = 0;

  logic [31:0] mem_m [bit [29:0]];

  int          n_beats;
  int          rsp_cyc;
  logic [31:0] rsp_data;
  logic        rsp_e;
  logic        ready_at_rsp, ready_after, extra_valid;
  logic [29:0] b_addr [2];
  logic [3:0]  b_we [2];
  logic [31:0] b_wdata [2];
  int          b_cyc [2];

  lsu_align #(.XLEN(32), .ADDR_W(32), .BRAM_LAT(1), .MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_align #(.XLEN(32), .ADDR_W(32), .BRAM_LAT(1), .MISALIGN_SPLIT(0)) u_dut_ns (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns), .rsp_err(rsp_err_ns),
    .mem_en(mem_en_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns),
    .mem_wdata(mem_wdata_ns), .mem_rdata(mem_rdata_ns)
  );

  always #5 clk = ~clk;

  // BRAM read model with one cycle of latency.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one request to the chosen instance and record its beats and response.
  task automatic run_req(input logic ns, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    int w;
    w = 0;
    while (!(ns ? req_ready_ns : req_ready) && w < 20) begin
      step();
      w++;
    end
    if (w >= 20) check_val("ready_timeout", 64'(0), 64'(1));
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (ns) req_valid_ns = 1'b1;
    else    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_valid_ns = 1'b0;
    n_beats = 0; rsp_cyc = -1; rsp_data = 32'h0; rsp_e = 1'b0; ready_at_rsp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b_addr[k] = '1; b_we[k] = '1; b_wdata[k] = '1; b_cyc[k] = -1;
    end
    for (int c = 1; c <= 12 && rsp_cyc < 0; c++) begin
      if (ns ? mem_en_ns : mem_en) begin
        if (n_beats < 2) begin
          b_addr[n_beats]  = ns ? mem_addr_ns : mem_addr;
          b_we[n_beats]    = ns ? mem_we_ns : mem_we;
          b_wdata[n_beats] = ns ? mem_wdata_ns : mem_wdata;
          b_cyc[n_beats]   = c;
        end
        n_beats++;
      end
      if (ns ? rsp_valid_ns : rsp_valid) begin
        rsp_cyc      = c;
        rsp_data     = ns ? rsp_rdata_ns : rsp_rdata;
        rsp_e        = ns ? rsp_err_ns : rsp_err;
        ready_at_rsp = ns ? req_ready_ns : req_ready;
      end
      step();
    end
    ready_after = ns ? req_ready_ns : req_ready;
    extra_valid = ns ? rsp_valid_ns : rsp_valid;
  endtask

  task automatic expect_rsp(input string tag, input int beats, input int lat,
                            input logic [31:0] data, input logic err);
    check_val({tag, ".beats"}, 64'(n_beats), 64'(beats));
    check_val({tag, ".lat"}, 64'(rsp_cyc), 64'(lat));
    check_val({tag, ".rdata"}, 64'(rsp_data), 64'(data));
    check_val({tag, ".err"}, 64'(rsp_e), 64'(err));
    check_val({tag, ".ready"}, 64'({ready_at_rsp, ready_after, extra_valid}), 64'(3'b010));
  endtask

  task automatic expect_beat(input string tag, input int k, input logic [29:0] addr,
                             input logic [3:0] we, input logic [31:0] wd);
    check_val({tag, ".addr"}, 64'(b_addr[k]), 64'(addr));
    check_val({tag, ".we"}, 64'(b_we[k]), 64'(we));
    check_val({tag, ".wdata"}, 64'(b_wdata[k]), 64'(wd));
    check_val({tag, ".cyc"}, 64'(b_cyc[k]), 64'(k + 1));
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    check_val("rst.ctl", 64'({req_ready, rsp_valid, rsp_err, mem_en, mem_we}), 64'(0));
    check_val("rst.data", 64'({rsp_rdata, mem_wdata}), 64'(0));
    check_val("rst.addr", 64'(mem_addr), 64'(0));
    reset_n = 1'b1;
    step();
    check_val("rst.ready", 64'({req_ready, req_ready_ns}), 64'(2'b11));

    // 1: aligned word store
    run_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    expect_beat("t1.b0", 0, 30'h40, 4'b1111, 32'hDEADBEEF);
    expect_rsp("t1", 1, 2, 32'h0, 1'b0);

    // 2: sub-word loads from one word
    mem_m[30'h40] = 32'h80FF1234;
    run_req(1'b0, 1'b0, 3'b000, 32'h103, 32'h0);
    expect_beat("t2lb.b0", 0, 30'h40, 4'b0000, 32'h0);
    expect_rsp("t2lb", 1, 3, 32'hFFFFFF80, 1'b0);
    run_req(1'b0, 1'b0, 3'b100, 32'h103, 32'h0);
    expect_rsp("t2lbu", 1, 3, 32'h00000080, 1'b0);
    run_req(1'b0, 1'b0, 3'b001, 32'h102, 32'h0);
    expect_rsp("t2lh", 1, 3, 32'hFFFF80FF, 1'b0);
    run_req(1'b0, 1'b0, 3'b101, 32'h102, 32'h0);
    expect_rsp("t2lhu", 1, 3, 32'h000080FF, 1'b0);
    run_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    expect_rsp("t2lw", 1, 3, 32'h80FF1234, 1'b0);

    // 3: split loads and an in-word misaligned load
    mem_m[30'h40] = 32'hAABBCCDD;
    mem_m[30'h41] = 32'h11223344;
    run_req(1'b0, 1'b0, 3'b010, 32'h102, 32'h0);
    expect_beat("t3.b0", 0, 30'h40, 4'b0000, 32'h0);
    expect_beat("t3.b1", 1, 30'h41, 4'b0000, 32'h0);
    expect_rsp("t3", 2, 4, 32'h3344AABB, 1'b0);
    run_req(1'b0, 1'b0, 3'b010, 32'h101, 32'h0);
    expect_rsp("t3lw1", 2, 4, 32'h44AABBCC, 1'b0);
    run_req(1'b0, 1'b0, 3'b001, 32'h101, 32'h0);
    expect_rsp("t3lh1", 1, 3, 32'hFFFFBBCC, 1'b0);

    // 4: split halfword store, then a byte store through funct3 100
    run_req(1'b0, 1'b1, 3'b001, 32'h107, 32'h00005678);
    expect_beat("t4.b0", 0, 30'h41, 4'b1000, 32'h78000000);
    expect_beat("t4.b1", 1, 30'h42, 4'b0001, 32'h00000056);
    expect_rsp("t4", 2, 3, 32'h0, 1'b0);
    run_req(1'b0, 1'b1, 3'b100, 32'h102, 32'h000000AB);
    expect_beat("t4sb.b0", 0, 30'h40, 4'b0100, 32'h00AB0000);
    expect_rsp("t4sb", 1, 2, 32'h0, 1'b0);

    // 5: error paths
    run_req(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    expect_rsp("t5ns_lw", 0, 1, 32'h0, 1'b1);
    run_req(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
    expect_rsp("t5ns_lh", 1, 3, 32'h0, 1'b0);
    run_req(1'b0, 1'b0, 3'b011, 32'h100, 32'h0);
    expect_rsp("t5ld", 0, 1, 32'h0, 1'b1);
    run_req(1'b0, 1'b0, 3'b111, 32'h100, 32'h0);
    expect_rsp("t5f7", 0, 1, 32'h0, 1'b1);
    run_req(1'b0, 1'b1, 3'b110, 32'h100, 32'h12345678);
    expect_rsp("t5s6", 0, 1, 32'h0, 1'b1);

    // 6: word-address wrap on the second beat
    mem_m[30'h3FFFFFFF] = 32'h12345678;
    mem_m[30'h0]        = 32'h9ABCDEF0;
    run_req(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    expect_beat("t6.b0", 0, 30'h3FFFFFFF, 4'b0000, 32'h0);
    expect_beat("t6.b1", 1, 30'h0, 4'b0000, 32'h0);
    expect_rsp("t6", 2, 4, 32'hDEF01234, 1'b0);

    // 6: reset asserted while the load waits for BRAM data
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check_val("t6r.issue", 64'(mem_en), 64'(1));
    step();
    reset_n = 1'b0;
    step();
    check_val("t6r.ctl", 64'({req_ready, rsp_valid, rsp_err, mem_en, mem_we}), 64'(0));
    check_val("t6r.data", 64'({rsp_rdata, mem_wdata}), 64'(0));
    check_val("t6r.addr", 64'(mem_addr), 64'(0));
    step();
    reset_n = 1'b1;
    step();
    check_val("t6r.ready", 64'({req_ready, rsp_valid}), 64'(2'b10));
    step();
    check_val("t6r.novalid", 64'(rsp_valid), 64'(0));
    run_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    expect_rsp("t6r.after", 1, 3, 32'hAABBCCDD, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
